// File: rtl/alu.sv
// alu: registered 16-function ALU with unsigned operands.
// The result appears one clock after the inputs are sampled.
// Optional macro ALU_FLAGS_EN adds a registered one-hot class flag output ALU_FLAGS.
//
// Output semantics: OUT_VALID is high for exactly the cycles in which ALU_OUT
// holds the result of an operation enabled at the previous rising edge. A low
// EN clears both ALU_OUT and OUT_VALID. There is no hold and no back-pressure.
module alu #(
    parameter int OPER_WIDTH = 8,
    parameter int OUT_WIDTH  = 16   // must equal 2*OPER_WIDTH so a full product fits
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [OPER_WIDTH-1:0] A,
    input  logic [OPER_WIDTH-1:0] B,
    input  logic [3:0]            ALU_FUN,
    input  logic                  EN,
    output logic [OUT_WIDTH-1:0]  ALU_OUT,
    output logic                  OUT_VALID
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]            ALU_FLAGS
`endif
);

    localparam logic [3:0] FUN_ADD  = 4'b0000;
    localparam logic [3:0] FUN_SUB  = 4'b0001;
    localparam logic [3:0] FUN_MUL  = 4'b0010;
    localparam logic [3:0] FUN_DIV  = 4'b0011;
    localparam logic [3:0] FUN_AND  = 4'b0100;
    localparam logic [3:0] FUN_OR   = 4'b0101;
    localparam logic [3:0] FUN_NAND = 4'b0110;
    localparam logic [3:0] FUN_NOR  = 4'b0111;
    localparam logic [3:0] FUN_XOR  = 4'b1000;
    localparam logic [3:0] FUN_XNOR = 4'b1001;
    localparam logic [3:0] FUN_EQ   = 4'b1010;
    localparam logic [3:0] FUN_GT   = 4'b1011;
    localparam logic [3:0] FUN_LT   = 4'b1100;
    localparam logic [3:0] FUN_SHR  = 4'b1101;
    localparam logic [3:0] FUN_SHL  = 4'b1110;

    localparam int EXT_W = OUT_WIDTH - OPER_WIDTH;

    logic [OUT_WIDTH-1:0] a_ext;
    logic [OUT_WIDTH-1:0] b_ext;
    logic [OUT_WIDTH-1:0] result;

    logic [OUT_WIDTH-1:0] alu_out_d, alu_out_q;
    logic                 valid_d,   valid_q;

    // Both operands are zero-extended to the output width before any function.
    assign a_ext = {{EXT_W{1'b0}}, A};
    assign b_ext = {{EXT_W{1'b0}}, B};

    // Function decode; every code has a defined result, and NOP falls through to 0.
    always_comb begin
        result = '0;
        case (ALU_FUN)
            FUN_ADD:  result = a_ext + b_ext;
            FUN_SUB:  result = a_ext - b_ext;
            FUN_MUL:  result = a_ext * b_ext;
            FUN_DIV:  result = (B == '0) ? '0 : (a_ext / b_ext);
            FUN_AND:  result = a_ext & b_ext;
            FUN_OR:   result = a_ext | b_ext;
            FUN_NAND: result = ~(a_ext & b_ext);
            FUN_NOR:  result = ~(a_ext | b_ext);
            FUN_XOR:  result = a_ext ^ b_ext;
            FUN_XNOR: result = ~(a_ext ^ b_ext);
            FUN_EQ:   result = (A == B) ? OUT_WIDTH'(1) : '0;
            FUN_GT:   result = (A >  B) ? OUT_WIDTH'(2) : '0;
            FUN_LT:   result = (A <  B) ? OUT_WIDTH'(3) : '0;
            FUN_SHR:  result = a_ext >> 1;
            FUN_SHL:  result = a_ext << 1;
            default:  result = '0;
        endcase
    end

    // Next-state: load when enabled, otherwise clear (no hold).
    always_comb begin
        alu_out_d = '0;
        valid_d   = 1'b0;
        if (EN) begin
            alu_out_d = result;
            valid_d   = 1'b1;
        end
    end

    // Output registers with synchronous active-low reset taking priority over EN.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            alu_out_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            valid_q   <= valid_d;
        end
    end

    assign ALU_OUT   = alu_out_q;
    assign OUT_VALID = valid_q;

`ifdef ALU_FLAGS_EN
    logic [3:0] flags_d, flags_q;

    // Class decode, one-hot {SHIFT, CMP, LOGIC, ARITH}; NOP and disabled cycles give 0.
    always_comb begin
        flags_d = 4'b0000;
        if (EN) begin
            if (ALU_FUN <= FUN_DIV)       flags_d = 4'b0001;
            else if (ALU_FUN <= FUN_XNOR) flags_d = 4'b0010;
            else if (ALU_FUN <= FUN_LT)   flags_d = 4'b0100;
            else if (ALU_FUN <= FUN_SHL)  flags_d = 4'b1000;
            else                          flags_d = 4'b0000;
        end
    end

    // Flag register, updated alongside the result register.
    always_ff @(posedge CLK) begin
        if (!RST) flags_q <= 4'b0000;
        else      flags_q <= flags_d;
    end

    assign ALU_FLAGS = flags_q;
`endif

endmodule

// File: tb/tb_alu.sv
// tb_alu: table-driven directed bench for alu, plus hand sequences for
// reset priority, enable drop/re-raise, back-to-back issue and mid-cycle input changes.
module tb_alu;

    logic        CLK;
    logic        RST;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  ALU_FUN;
    logic        EN;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic [3:0]  flags;

    int checks;
    int errors;

    alu #(.OPER_WIDTH(8), .OUT_WIDTH(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .B         (B),
        .ALU_FUN   (ALU_FUN),
        .EN        (EN),
        .ALU_OUT   (ALU_OUT),
        .OUT_VALID (OUT_VALID)
`ifdef ALU_FLAGS_EN
        ,
        .ALU_FLAGS (flags)
`endif
    );

`ifndef ALU_FLAGS_EN
    assign flags = 4'b0000;
`endif

    // clock / reset block
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  fun;
        logic [15:0] exp_out;
        logic [3:0]  exp_flags;
        string       name;
    } vec_t;

    vec_t vecs[$];

    localparam logic [3:0] F_AR = 4'b0001;
    localparam logic [3:0] F_LG = 4'b0010;
    localparam logic [3:0] F_CM = 4'b0100;
    localparam logic [3:0] F_SH = 4'b1000;
    localparam logic [3:0] F_NO = 4'b0000;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_flags(input string name, input logic [3:0] exp);
`ifdef ALU_FLAGS_EN
        checks++;
        if (flags !== exp) begin
            errors++;
            $display("FAIL %s flags: got %b expected %b", name, flags, exp);
        end
`endif
    endtask

    // driver: present inputs away from the edge, then sample just after the edge
    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun, input logic en);
        @(negedge CLK);
        A       = a;
        B       = b;
        ALU_FUN = fun;
        EN      = en;
        @(posedge CLK);
        #1;
    endtask

    task automatic add_vec(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun,
                           input logic [15:0] exp_out, input logic [3:0] exp_flags, input string name);
        vec_t v;
        v.a = a; v.b = b; v.fun = fun; v.exp_out = exp_out; v.exp_flags = exp_flags; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        RST     = 1'b1;
        EN      = 1'b0;
        A       = '0;
        B       = '0;
        ALU_FUN = '0;

        // hand-computed vectors
        add_vec(8'd250, 8'd140, 4'b0000, 16'd390,    F_AR, "add_250_140");
        add_vec(8'd250, 8'd140, 4'b0001, 16'd110,    F_AR, "sub_250_140");
        add_vec(8'd15,  8'd10,  4'b0010, 16'd150,    F_AR, "mul_15_10");
        add_vec(8'd100, 8'd50,  4'b0011, 16'd2,      F_AR, "div_100_50");
        add_vec(8'd9,   8'd0,   4'b0011, 16'd0,      F_AR, "div_by_zero");
        add_vec(8'h96,  8'hF0,  4'b0100, 16'h0090,   F_LG, "and");
        add_vec(8'h96,  8'hF0,  4'b0101, 16'h00F6,   F_LG, "or");
        add_vec(8'd9,   8'd3,   4'b0110, 16'hFFFE,   F_LG, "nand");
        add_vec(8'd9,   8'd3,   4'b0111, 16'hFFF4,   F_LG, "nor");
        add_vec(8'd9,   8'd3,   4'b1000, 16'h000A,   F_LG, "xor");
        add_vec(8'd9,   8'd3,   4'b1001, 16'hFFF5,   F_LG, "xnor");
        add_vec(8'd9,   8'd3,   4'b1010, 16'd0,      F_CM, "eq_false");
        add_vec(8'd9,   8'd3,   4'b1011, 16'd2,      F_CM, "gt_true");
        add_vec(8'd9,   8'd3,   4'b1100, 16'd0,      F_CM, "lt_false");
        add_vec(8'd9,   8'd3,   4'b1101, 16'd4,      F_SH, "shr");
        add_vec(8'd9,   8'd3,   4'b1110, 16'd18,     F_SH, "shl");
        add_vec(8'd9,   8'd3,   4'b1111, 16'd0,      F_NO, "nop");
        add_vec(8'd7,   8'd7,   4'b1010, 16'd1,      F_CM, "eq_true");
        add_vec(8'd2,   8'd5,   4'b1100, 16'd3,      F_CM, "lt_true");
        add_vec(8'd2,   8'd5,   4'b1011, 16'd0,      F_CM, "gt_false");
        add_vec(8'd255, 8'd255, 4'b0010, 16'd65025,  F_AR, "mul_max");
        add_vec(8'd255, 8'd255, 4'b0000, 16'd510,    F_AR, "add_max");
        add_vec(8'd3,   8'd9,   4'b0001, 16'hFFFA,   F_AR, "sub_wrap");
        add_vec(8'h80,  8'd0,   4'b1110, 16'h0100,   F_SH, "shl_msb");
        add_vec(8'hFF,  8'd0,   4'b1110, 16'h01FE,   F_SH, "shl_ff");
        add_vec(8'h81,  8'd0,   4'b1101, 16'h0040,   F_SH, "shr_81");
        add_vec(8'd200, 8'd7,   4'b0011, 16'd28,     F_AR, "div_200_7");

        // reset has priority over EN
        @(negedge CLK);
        RST = 1'b0;
        apply(8'd4, 8'd5, 4'b0000, 1'b1);
        check16("reset_out", ALU_OUT, 16'h0000);
        check1("reset_valid", OUT_VALID, 1'b0);
        check_flags("reset", F_NO);
        @(negedge CLK);
        RST = 1'b1;

        // table: EN held high, one result per cycle
        foreach (vecs[i]) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].fun, 1'b1);
            check16(vecs[i].name, ALU_OUT, vecs[i].exp_out);
            check1({vecs[i].name, "_valid"}, OUT_VALID, 1'b1);
            check_flags(vecs[i].name, vecs[i].exp_flags);
        end

        // enable drop clears, re-raise gives a fresh result one cycle later
        apply(8'd250, 8'd140, 4'b0000, 1'b1);
        check16("en_pre_add", ALU_OUT, 16'd390);
        apply(8'd1, 8'd2, 4'b0000, 1'b0);
        check16("en_low_out", ALU_OUT, 16'h0000);
        check1("en_low_valid", OUT_VALID, 1'b0);
        check_flags("en_low", F_NO);
        apply(8'd1, 8'd2, 4'b0000, 1'b1);
        check16("en_reraise_out", ALU_OUT, 16'd3);
        check1("en_reraise_valid", OUT_VALID, 1'b1);

        // mid-cycle input changes must not reach the output before the next edge
        #2;
        A = 8'd100; B = 8'd100; ALU_FUN = 4'b0010;
        @(negedge CLK);
        check16("midcycle_hold", ALU_OUT, 16'd3);
        @(posedge CLK);
        #1;
        check16("midcycle_next", ALU_OUT, 16'd10000);

        // synchronous reset mid-run clears a valid result even with EN high
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check16("reset_mid_out", ALU_OUT, 16'h0000);
        check1("reset_mid_valid", OUT_VALID, 1'b0);
        @(negedge CLK);
        RST = 1'b1;

        // randomised operands on a few closed-form functions
        for (int k = 0; k < 20; k++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            apply(ra, rb, 4'b0000, 1'b1);
            check16("rand_add", ALU_OUT, {8'h00, ra} + {8'h00, rb});
            apply(ra, rb, 4'b0010, 1'b1);
            check16("rand_mul", ALU_OUT, {8'h00, ra} * {8'h00, rb});
        end

        apply(8'd0, 8'd0, 4'b1111, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
